// File: rtl/fpga_tx_sched.sv
// fpga_tx_sched: round-robin arbiter, tick generator and frame sequencer for fpga_tx_com.
// Define FPGA_TX_SCHED_PRIO_EN to give requester 0 absolute priority.
`timescale 1ns/1ps
module fpga_tx_sched #(
    parameter int N_REQ   = 4,
    parameter int DIV     = 50,
    parameter int TIMEOUT = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [12*N_REQ-1:0] data_in,
    output logic [N_REQ-1:0]   grant,
    output logic               done,
    output logic               busy,
    output logic               sync_tx,
    output logic               start_tx,
    output logic [3:0]         word1,
    output logic [3:0]         word2,
    output logic [3:0]         word3,
    input  logic               ready_tx,
    output logic               tx_rst,
    output logic               timeout_err
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_RDY, DRAIN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tcnt;
    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic          found;
    logic          hit0;
    logic          abort;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (cnt == CW'(DIV - 1))
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign sync_tx = (cnt == CW'(DIV - 1));
    assign busy    = (state != IDLE);
    assign tx_rst  = reset | abort;

`ifdef FPGA_TX_SCHED_PRIO_EN
    assign hit0 = req[0];
`else
    assign hit0 = 1'b0;
`endif

    // Search starts at ptr; the first asserted request wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        if (hit0) begin
            found = 1'b1;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                int idx;
                idx = (int'(ptr) + k) % N_REQ;
                if (!found && req[idx]) begin
                    win   = PW'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            done        <= 1'b0;
            start_tx    <= 1'b0;
            word1       <= '0;
            word2       <= '0;
            word3       <= '0;
            tcnt        <= '0;
            abort       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            grant    <= '0;
            done     <= 1'b0;
            start_tx <= 1'b0;
            abort    <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant <= N_REQ'(1) << win;
                        {word1, word2, word3} <= data_in[12*int'(win) +: 12];
                        if (!hit0)
                            ptr <= (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
                        state <= START;
                    end
                end
                START: begin
                    if (sync_tx) begin
                        start_tx <= 1'b1;
                        tcnt     <= '0;
                        state    <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (ready_tx) begin
                        state <= DRAIN;
                    end else if (tcnt == TW'(TIMEOUT)) begin
                        timeout_err <= 1'b1;
                        abort       <= 1'b1;
                        state       <= IDLE;
                    end else if (sync_tx) begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (!ready_tx) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_tx_sched.sv
// Directed bench for fpga_tx_sched with N_REQ=4, DIV=4, TIMEOUT=32.
`timescale 1ns/1ps
module tb_fpga_tx_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [47:0] data_in;
    logic [3:0]  grant;
    logic        done, busy, sync_tx, start_tx;
    logic [3:0]  word1, word2, word3;
    logic        ready_tx;
    logic        tx_rst, timeout_err;

    int n_chk  = 0;
    int n_fail = 0;

    fpga_tx_sched #(.N_REQ(4), .DIV(4), .TIMEOUT(32)) dut (
        .clk(clk), .reset(reset), .req(req), .data_in(data_in),
        .grant(grant), .done(done), .busy(busy), .sync_tx(sync_tx),
        .start_tx(start_tx), .word1(word1), .word2(word2), .word3(word3),
        .ready_tx(ready_tx), .tx_rst(tx_rst), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete frame; ready_tx is returned 12 ticks after start_tx.
    task automatic frame(input string tag, input logic [3:0] r,
                         input logic [47:0] d, input logic [3:0] eg,
                         input logic [11:0] ew, input bit hold);
        int  n;
        int  starts;
        bit  seen;
        req     = r;
        data_in = d;
        for (int i = 0; i < 20; i++) begin
            if (grant != 4'b0) break;
            @(negedge clk);
        end
        check({tag, "_grant"}, grant, eg);
        check({tag, "_words"}, {word1, word2, word3}, ew);
        if (!hold) req = 4'b0;
        seen   = 1'b0;
        starts = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) check({tag, "_grant_pulse"}, grant, 4'b0);
            if (start_tx) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_start_seen"}, seen, 1);
        n = 0;
        for (int i = 0; i < 200 && n < 12; i++) begin
            @(negedge clk);
            if (sync_tx) n++;
            if (start_tx) starts++;
        end
        ready_tx = 1'b1;
        repeat (2) @(negedge clk);
        check({tag, "_busy_drain"}, busy, 1);
        check({tag, "_no_early_done"}, done, 0);
        ready_tx = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_extra_start"}, starts, 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int  n;
        bit  seen;
        reset    = 1'b1;
        req      = 4'b0;
        data_in  = 48'h0;
        ready_tx = 1'b0;

        // 1: reset and free-running tick
        repeat (3) @(negedge clk);
        check("rst_tx_rst", tx_rst, 1);
        check("rst_outs", {grant, done, busy, start_tx, timeout_err}, 0);
        check("rst_words", {word1, word2, word3}, 0);
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("tick_%0d", k), sync_tx, (k % 4) == 3);
        end
        check("idle_outs", {grant, done, busy, start_tx, tx_rst, timeout_err}, 0);

        // 2: single frame from requester 0
        frame("t2", 4'b0001, 48'h000_000_000_A5C, 4'b0001, 12'hA5C, 1'b0);

        // 6: stale ready_tx in IDLE is ignored
        ready_tx = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_stale_busy", busy, 0);
        check("t6_stale_grant", grant, 0);
        ready_tx = 1'b0;
        frame("t6", 4'b0010, 48'h000_000_3C7_000, 4'b0010, 12'h3C7, 1'b0);

        // 4: transmitter hangs, abort after 32 ticks
        req     = 4'b0100;
        data_in = 48'h000_9E1_000_000;
        for (int i = 0; i < 20; i++) begin
            if (grant != 4'b0) break;
            @(negedge clk);
        end
        check("t4_grant", grant, 4'b0100);
        check("t4_words", {word1, word2, word3}, 12'h9E1);
        req  = 4'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (start_tx) begin
                seen = 1'b1;
                break;
            end
        end
        check("t4_start_seen", seen, 1);
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            if (tx_rst) break;
            if (sync_tx) n++;
        end
        check("t4_tx_rst", tx_rst, 1);
        check("t4_ticks", n, 32);
        check("t4_err", timeout_err, 1);
        check("t4_busy", busy, 0);
        check("t4_no_done", seen, 0);
        @(negedge clk);
        check("t4_rst_pulse", tx_rst, 0);
        frame("t4b", 4'b1000, 48'h6B2_000_000_000, 4'b1000, 12'h6B2, 1'b0);
        check("t4_sticky", timeout_err, 1);

        // 5: reset in WAIT_RDY
        req     = 4'b0001;
        data_in = 48'h000_000_000_D40;
        for (int i = 0; i < 20; i++) begin
            if (grant != 4'b0) break;
            @(negedge clk);
        end
        check("t5_grant", grant, 4'b0001);
        req = 4'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (start_tx) break;
        end
        repeat (2) @(negedge clk);
        check("t5_busy_pre", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check("t5_tx_rst", tx_rst, 1);
        check("t5_outs", {grant, done, busy, start_tx, sync_tx, timeout_err}, 0);
        check("t5_words", {word1, word2, word3}, 0);
        reset = 1'b0;

        // 3: all requesters held; pointer restarts at 0 after reset
        data_in = 48'h444_333_222_111;
`ifdef FPGA_TX_SCHED_PRIO_EN
        frame("t3_f0", 4'b1111, data_in, 4'b0001, 12'h111, 1'b1);
        frame("t3_f1", 4'b1111, data_in, 4'b0001, 12'h111, 1'b1);
        frame("t3_f2", 4'b1111, data_in, 4'b0001, 12'h111, 1'b1);
        frame("t3_f3", 4'b1111, data_in, 4'b0001, 12'h111, 1'b1);
`else
        frame("t3_f0", 4'b1111, data_in, 4'b0001, 12'h111, 1'b1);
        frame("t3_f1", 4'b1111, data_in, 4'b0010, 12'h222, 1'b1);
        frame("t3_f2", 4'b1111, data_in, 4'b0100, 12'h333, 1'b1);
        frame("t3_f3", 4'b1111, data_in, 4'b1000, 12'h444, 1'b1);
`endif
        req = 4'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
